mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 6, cycles from acceptance to completion (legal 1..31).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, max outstanding transactions (legal 1..14).
REQ-003 SHALL have parameter MEM_ADDR_BITS, default 8, log2 of 64-bit backing lines.
REQ-004 SHALL have port clock, input, 1, single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset; block in reset while 0.
REQ-006 SHALL have port proc2Dmem_command, input, 2, command: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; 3 treated as BUS_NONE.
REQ-007 SHALL have port proc2Dmem_addr, input, XLEN, byte address; line index = addr[MEM_ADDR_BITS+2:3]; bits [2:0] and upper bits ignored (alias).
REQ-008 SHALL have port proc2Dmem_data, input, 64, store data.
REQ-009 SHALL have port Dmem2proc_response, output, 4, same-cycle acceptance tag; 0 = refused/no command.
REQ-010 SHALL have port Dmem2proc_data, output, 64, completion data; 0 when no completion.
REQ-011 SHALL have port Dmem2proc_tag, output, 4, completion tag; 0 when no completion.

Function
REQ-012 Dmem2proc_response SHALL be combinational from the command and registered queue state.
REQ-013 A command SHALL be accepted iff it is BUS_LOAD/BUS_STORE and registered occupancy < QUEUE_DEPTH; a slot freed by a completion in the same cycle is not reusable until the next cycle.
REQ-014 On acceptance, response SHALL equal next_tag; next_tag resets to 1, increments by 1 per acceptance, wraps 15->1, never 0.
REQ-015 Refused commands SHALL have no side effect (no write, no tag advance, response 0); requester retries.
REQ-016 Accepted BUS_STORE SHALL write proc2Dmem_data into the indexed line at that posedge; the entry's completion data SHALL be the stored value.
REQ-017 Accepted BUS_LOAD SHALL capture the line contents at accept time into the entry, including any store accepted in an earlier cycle.
REQ-018 Entries SHALL be held in a FIFO, each with a down-counter loaded at accept.
REQ-019 Command accepted in cycle N SHALL yield Dmem2proc_tag = its tag and Dmem2proc_data = its data, both registered, for exactly cycle N+MEM_LATENCY; entry then retires.
REQ-020 At most one completion per cycle; completions SHALL occur in acceptance order; back-to-back accepts SHALL complete in consecutive cycles.
REQ-021 Simultaneous accept and completion in one cycle SHALL both take effect; occupancy changes by +1, -1, or 0 accordingly.
REQ-022 Tags of outstanding entries SHALL be unique (guaranteed by QUEUE_DEPTH <= 14 and in-order wrap).
REQ-023 Backing memory SHALL be synchronous-write with no reset; contents are undefined until written.

Reset
REQ-024 While reset = 0: FIFO empty, occupancy 0, next_tag = 1, Dmem2proc_tag = 0, Dmem2proc_data = 0, Dmem2proc_response = 0.
REQ-025 Reset asserted mid-operation SHALL discard all outstanding entries without completion; memory writes already committed SHALL remain.
REQ-026 First command after reset deassertion SHALL be accepted with tag 1.

Verification
REQ-027 Store addr 0x40 data 0xDEADBEEF_01234567 at cycle 0 -> response 1; cycle 6 tag 1, data 0xDEADBEEF_01234567; then load 0x44 -> response 2, data 0xDEADBEEF_01234567 six cycles later.
REQ-028 Five back-to-back loads (defaults) -> responses 1,2,3,4,0; fifth is refused; completions tags 1..4 in cycles 6..9; retry accepted with tag 5 from cycle 6 onward.
REQ-029 Store 0xA to line 3 at cycle 0, load line 3 at cycle 1 -> load completes cycle 7 with 0xA.
REQ-030 Issue 20 accepted commands across a wrap -> tags 1..15,1..5, never 0, each completion exactly MEM_LATENCY after its accept.
REQ-031 Assert reset with 3 outstanding -> outputs 0 immediately; no completions after release; next accept gets tag 1; previously stored data readable.
REQ-032 Command 3 or BUS_NONE every cycle -> response 0, no completions, memory unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Latency-modelled data memory: accepts one load/store per cycle, tags it,
// and returns the result in order a fixed MEM_LATENCY cycles later.
module mem_responder #(
  parameter int MEM_LATENCY   = 6,
  parameter int QUEUE_DEPTH   = 4,
  parameter int MEM_ADDR_BITS = 8,
  parameter int XLEN          = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  output logic [3:0]      Dmem2proc_response,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Dmem2proc_tag
);

  localparam int PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW    = $clog2(QUEUE_DEPTH + 1);
  localparam int LINES = 1 << MEM_ADDR_BITS;

  localparam logic [PW-1:0] LAST     = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(QUEUE_DEPTH);
  localparam logic [4:0]    LOAD_CNT = 5'(MEM_LATENCY - 1);
  localparam logic          QUEUED   = (MEM_LATENCY > 1);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2,
    BUS_RSVD  = 2'd3
  } bus_cmd_e;

  logic [63:0] mem [LINES];

  logic [MEM_ADDR_BITS-1:0] line_idx;
  logic                     unused_addr;
  logic                     is_load;
  logic                     is_store;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [63:0]              acc_data;

  logic [3:0]    next_tag;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [3:0]  ent_tag  [QUEUE_DEPTH];
  logic [63:0] ent_data [QUEUE_DEPTH];
  logic [4:0]  ent_cnt  [QUEUE_DEPTH];

  assign line_idx    = proc2Dmem_addr[MEM_ADDR_BITS+2:3];
  assign unused_addr = ^{proc2Dmem_addr[XLEN-1:MEM_ADDR_BITS+3],
                         proc2Dmem_addr[2:0]};

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    unique case (bus_cmd_e'(proc2Dmem_command))
      BUS_LOAD:  is_load  = 1'b1;
      BUS_STORE: is_store = 1'b1;
      default:   ;
    endcase
  end

  // Occupancy is the registered count: a slot retired this cycle frees next cycle.
  assign accept = reset && (is_load || is_store) && (count < FULL);
  assign Dmem2proc_response = accept ? next_tag : 4'd0;

  assign acc_data = is_store ? proc2Dmem_data : mem[line_idx];
  assign push     = accept && QUEUED;
  assign pop      = (count != '0) && (ent_cnt[rd_ptr] == 5'd1);

  always_ff @(posedge clock) begin
    if (accept && is_store)
      mem[line_idx] <= proc2Dmem_data;
  end

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      next_tag       <= 4'd1;
      Dmem2proc_tag  <= 4'd0;
      Dmem2proc_data <= 64'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_tag[i]  <= 4'd0;
        ent_data[i] <= 64'd0;
        ent_cnt[i]  <= 5'd0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (ent_cnt[i] != 5'd0)
          ent_cnt[i] <= ent_cnt[i] - 5'd1;
      end

      if (push) begin
        ent_tag[wr_ptr]  <= next_tag;
        ent_data[wr_ptr] <= acc_data;
        ent_cnt[wr_ptr]  <= LOAD_CNT;
        wr_ptr           <= bump(wr_ptr);
      end

      if (pop)
        rd_ptr <= bump(rd_ptr);

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (accept)
        next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;

      // With unit latency the accept itself feeds the completion register.
      if (!QUEUED) begin
        Dmem2proc_tag  <= accept ? next_tag : 4'd0;
        Dmem2proc_data <= accept ? acc_data : 64'd0;
      end else if (pop) begin
        Dmem2proc_tag  <= ent_tag[rd_ptr];
        Dmem2proc_data <= ent_data[rd_ptr];
      end else begin
        Dmem2proc_tag  <= 4'd0;
        Dmem2proc_data <= 64'd0;
      end
    end
  end

endmodule
